// File: rtl/mmio_rgb_pwm_if.sv
// Load/store port bundle between the core's data bus and the RGB PWM / timebase peripheral.
// The master drives strobes, address and store data; the slave returns load data and the window hit.
interface mmio_rgb_pwm_if;
    logic        wen;
    logic        ren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic        hit;

    modport master (
        output wen, ren, addr, wdata, wmask,
        input  rdata, hit
    );

    modport slave (
        input  wen, ren, addr, wdata, wmask,
        output rdata, hit
    );
endinterface

// File: rtl/mmio_rgb_pwm.sv
// Memory-mapped RGB LED PWM with double-buffered duty plus free-running microsecond/millisecond counters.
// Duty changes reach the pins only at a PWM period boundary, so a sweep never produces a partial period.
module mmio_rgb_pwm #(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FFE0,
    parameter int unsigned PWM_BITS    = 8,
    parameter int unsigned PRESCALE    = 1,
    parameter int unsigned CLKS_PER_US = 12,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    mmio_rgb_pwm_if.slave bus,
    output logic          RGB_R,
    output logic          RGB_G,
    output logic          RGB_B
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned US_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_DUTY   = 2'd1,
        REG_MICROS = 2'd2,
        REG_MILLIS = 2'd3
    } reg_e;

    logic                     en;
    logic [2:0][PWM_BITS-1:0] duty_shadow;
    logic [2:0][PWM_BITS-1:0] duty_active;
    logic [PS_W-1:0]          presc;
    logic [PWM_BITS-1:0]      pwm_cnt;
    logic [US_W-1:0]          us_div;
    logic [9:0]               ms_sub;
    logic [31:0]              micros;
    logic [31:0]              millis;

    reg_e        sel;
    logic        wr;
    logic        pwm_tick;
    logic        pwm_wrap;
    logic        us_tick;
    logic [31:0] rd_word;
    logic [2:0]  lit;

    // Byte-offset bits and the unused upper byte lane carry no information for this block.
    logic unused_bits;
    assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:24], bus.wmask[3]};

    assign bus.hit  = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign sel      = reg_e'(bus.addr[3:2]);
    assign wr       = bus.wen && bus.hit;
    assign pwm_tick = (presc == PS_W'(PRESCALE - 1));
    assign pwm_wrap = pwm_tick && (pwm_cnt == '1);
    assign us_tick  = (us_div == US_W'(CLKS_PER_US - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values,
    // which is what makes a same-cycle read and write return the old register contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en <= 1'b0;
        end else if (wr && sel == REG_CTRL && bus.wmask[0]) begin
            en <= bus.wdata[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_shadow <= '0;
        end else if (wr && sel == REG_DUTY) begin
            for (int c = 0; c < 3; c++) begin
                if (bus.wmask[c]) duty_shadow[c] <= bus.wdata[8*c +: PWM_BITS];
            end
        end
    end

    // While disabled the divider is parked at zero and the active duty follows the shadow,
    // so enabling starts a fresh period at pwm_cnt == 0 with the latest duty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc       <= '0;
            pwm_cnt     <= '0;
            duty_active <= '0;
        end else if (!en) begin
            presc       <= '0;
            pwm_cnt     <= '0;
            duty_active <= duty_shadow;
        end else begin
            presc <= pwm_tick ? '0 : presc + 1'b1;
            if (pwm_tick) pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_wrap) duty_active <= duty_shadow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            us_div <= '0;
            ms_sub <= '0;
            micros <= '0;
            millis <= '0;
        end else begin
            us_div <= us_tick ? '0 : us_div + 1'b1;
            if (us_tick) begin
                micros <= micros + 32'd1;
                if (ms_sub == 10'd999) begin
                    ms_sub <= '0;
                    millis <= millis + 32'd1;
                end else begin
                    ms_sub <= ms_sub + 10'd1;
                end
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        rd_word = '0;
        case (sel)
            REG_CTRL:   rd_word[0] = en;
            REG_DUTY: begin
                for (int c = 0; c < 3; c++) rd_word[8*c +: PWM_BITS] = duty_shadow[c];
            end
            REG_MICROS: rd_word = micros;
            REG_MILLIS: rd_word = millis;
            default:    rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rdata <= '0;
        end else if (bus.ren) begin
            bus.rdata <= bus.hit ? rd_word : '0;
        end
    end

    // Pins decode straight from flops, so an asynchronous reset darkens them without a clock.
    always_comb begin
        lit = '0;
        for (int c = 0; c < 3; c++) lit[c] = en && (pwm_cnt < duty_active[c]);
    end

    assign RGB_R = lit[0] ^ ACTIVE_LOW;
    assign RGB_G = lit[1] ^ ACTIVE_LOW;
    assign RGB_B = lit[2] ^ ACTIVE_LOW;

endmodule

// File: doc/mmio_rgb_pwm.md
# mmio_rgb_pwm

Memory-mapped RGB LED PWM and timebase peripheral on the processor's data bus, downstream of the core's load/store port and directly driving the board's RGB pins. The processor sets per-channel 8-bit duty cycles and reads free-running microsecond and millisecond counters, which the sine firmware uses to pace its colour sweeps. Duty updates are double-buffered and take effect only at a PWM period boundary, so the LEDs never glitch.

## Interface
- BASE_ADDR, 32'hFFFF_FFE0: word-aligned base of the 16-byte register window.
- PWM_BITS, 8: duty and PWM counter width.
- PRESCALE, 1: clocks per PWM counter step (≥1).
- CLKS_PER_US, 12: clocks per microsecond (12 MHz system clock).
- ACTIVE_LOW, 1: pin polarity; 1 means a lit LED drives 0.

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wen  in  1  store strobe, one cycle per store
- ren  in  1  load strobe, one cycle per load
- addr  in  32  byte address; bits [1:0] ignored
- wdata  in  32  store data
- wmask  in  4  byte enables for wdata
- rdata  out  32  registered load data
- hit  out  1  combinational: addr is inside the window
- RGB_R, RGB_G, RGB_B  out  1 each  LED pin drives

## Operation
- Window hit: addr[31:4] == BASE_ADDR[31:4]. Accesses outside the window are ignored, and their rdata is 0.
- Register map (word offset, byte address within the window):
  - 0x0 CTRL (R/W): bit0 EN, others read 0.
  - 0x4 DUTY (R/W shadow): [7:0] R, [15:8] G, [23:16] B, [31:24] read 0.
  - 0x8 MICROS (RO, 32-bit): writes ignored.
  - 0xC MILLIS (RO, 32-bit): writes ignored.
- Writes honour wmask per byte. A read of DUTY returns the shadow value, not the active value.
- PWM divider:
  - Prescale counter runs 0..PRESCALE-1.
  - Tick fires at PRESCALE-1.
  - On tick, pwm_cnt (PWM_BITS) increments and wraps 2^PWM_BITS-1 → 0.
- Active duty reload: all three channels load from shadow on the tick where pwm_cnt wraps to 0.
- Channel lit while EN && pwm_cnt < duty_active:
  - duty 0 is always dark.
  - duty 255 is lit 255 of 256 steps.
- Pin = lit XOR ACTIVE_LOW.
- EN=0:
  - Prescaler and pwm_cnt held at 0.
  - Active duty tracks shadow every cycle.
  - All channels dark.
- Timebase:
  - us divider 0..CLKS_PER_US-1 increments MICROS at terminal count.
  - ms sub-counter 0..999 counts MICROS increments and increments MILLIS at 999.
  - Both are 32-bit and wrap silently.
  - Runs regardless of EN.

## Timing
- Reset (async assert, sync release internally by flop behaviour):
  - CTRL=0, shadow and active duty=0.
  - All counters and dividers 0.
  - rdata=0.
  - Pins dark: 1 when ACTIVE_LOW.
- Reset mid-period forces dark pins immediately, without waiting for a clock.
- Store: register updates at the clk edge where wen && hit.
- Load: rdata valid on the cycle after ren. rdata holds until the next ren.
- Same-cycle read and write of one register returns the old value.
- Same-cycle MICROS/MILLIS increment and read returns the pre-increment value.
- EN 0→1 at edge n: pwm_cnt=0 at n+1, so the first lit cycle for nonzero duty is n+1.
- EN 1→0: pins dark the cycle after the write edge.
- Period: PRESCALE·2^PWM_BITS clocks (256 with defaults).
- Shadow write mid-period: current period completes with the old duty; the new duty applies from the next pwm_cnt==0 period.
- MICROS first increments after CLKS_PER_US clocks (12). MILLIS first increments after 12000 clocks.

## Test plan
- Reset check:
  - Stimulus: hold rst_n low, then release it. Read 0x0, 0x4, 0x8.
  - Required response: RGB pins all 1; reads return 0, 0, and a small MICROS value.
- Single-channel duty:
  - Stimulus: write DUTY=0x0000_0040, then CTRL=1.
  - Required response: RGB_R low exactly 64 of every 256 clocks, starting the cycle after the EN write; G and B stay 1.
- Double buffering:
  - Stimulus: at pwm_cnt=100 with R duty=0x40, write DUTY R=0xC0.
  - Required response: the current period still shows 64 low clocks; the next period shows 192.
- Byte mask:
  - Stimulus: with DUTY=0x00112233, write wdata=0xFFAA5500 with wmask=4'b0010.
  - Required response: DUTY reads back 0x00115533.
- Timebase:
  - Stimulus: run 12000 clocks after reset.
  - Required response: MICROS=1000, MILLIS=1. A write to 0x8 leaves MICROS unchanged.
- Limits and reset:
  - Stimulus: set duty 0 and duty 0xFF; separately, pulse rst_n low mid-period.
  - Required response: duty 0 keeps the pin 1 forever; duty 0xFF gives 255 low and 1 high per period. The rst_n pulse drives the pins to 1 immediately and CTRL reads 0.
